// File: rtl/pbus_pkg.sv
// Shared definitions for the peripheral-bus arbiter: FSM encoding, timer address windows and
// master ids.
package pbus_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [31:0] TC1_START = 32'h0000_7F00;
    localparam logic [31:0] TC1_END   = 32'h0000_7F0B;
    localparam logic [31:0] TC2_START = 32'h0000_7F10;
    localparam logic [31:0] TC2_END   = 32'h0000_7F1B;

    localparam logic MST_CPU = 1'b0;
    localparam logic MST_DMA = 1'b1;

    function automatic logic addr_in_window(input logic [31:0] addr);
        return ((addr >= TC1_START) && (addr <= TC1_END)) ||
               ((addr >= TC2_START) && (addr <= TC2_END));
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-request picker. Round-robin on ties by default; with PBUS_FIXED_PRIO_EN
// defined, master 0 always wins a tie.
module rr_arb2
    import pbus_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_gnt,
    output logic       o_winner,
    output logic       o_valid
);

    logic w_tie_winner;

`ifdef PBUS_FIXED_PRIO_EN
    logic w_unused_last_gnt;
    assign w_unused_last_gnt = i_last_gnt;
    assign w_tie_winner      = MST_CPU;
`else
    assign w_tie_winner = ~i_last_gnt;
`endif

    assign o_valid = |i_req;

    always_comb begin
        o_winner = MST_CPU;
        if (i_req == 2'b10) begin
            o_winner = MST_DMA;
        end else if (i_req == 2'b11) begin
            o_winner = w_tie_winner;
        end
    end

endmodule

// File: rtl/pbus_arbiter.sv
// Two-master peripheral-bus arbiter/sequencer feeding the TC1/TC2 bridge.
// Build option: PBUS_FIXED_PRIO_EN (fixed priority to master 0 instead of round-robin).
module pbus_arbiter
    import pbus_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 0,
    parameter int unsigned CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_done,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_done,
    output logic        m1_err,
    output logic [31:0] pr_a,
    output logic        pr_we,
    output logic [31:0] pr_wd,
    input  logic [31:0] pr_rd,
    output logic        busy,
    output logic        owner
);

    logic [1:0]       r_state;
    logic             r_owner;
    logic             r_last_gnt;
    logic             r_we;
    logic             r_err;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic [CNT_W-1:0] r_cnt;

    logic             w_winner;
    logic             w_valid;
    logic             w_sel_we;
    logic [31:0]      w_sel_addr;
    logic [31:0]      w_sel_wdata;
    logic             w_drive;
    logic             w_last;
    logic             w_resp;

    rr_arb2 u_rr_arb2 (
        .i_req      ({m1_req, m0_req}),
        .i_last_gnt (r_last_gnt),
        .o_winner   (w_winner),
        .o_valid    (w_valid)
    );

    always_comb begin
        if (w_winner == MST_DMA) begin
            w_sel_we    = m1_we;
            w_sel_addr  = m1_addr;
            w_sel_wdata = m1_wdata;
        end else begin
            w_sel_we    = m0_we;
            w_sel_addr  = m0_addr;
            w_sel_wdata = m0_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= MST_CPU;
            r_last_gnt <= MST_DMA;
            r_we       <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_owner    <= w_winner;
                        r_last_gnt <= w_winner;
                        r_we       <= w_sel_we;
                        r_addr     <= {w_sel_addr[31:2], 2'b00};
                        r_wdata    <= w_sel_wdata;
                        r_err      <= !addr_in_window(w_sel_addr);
                        r_cnt      <= CNT_W'(WAIT_CYCLES);
                        r_state    <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (w_last) begin
                        // Writes and rejected addresses return zero data.
                        r_rdata <= (r_we || r_err) ? '0 : pr_rd;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_drive = (r_state == ST_ACCESS) && !r_err;
    assign w_last  = (r_cnt == '0);
    assign w_resp  = (r_state == ST_RESP);

    assign pr_a  = w_drive ? r_addr : '0;
    assign pr_wd = w_drive ? r_wdata : '0;
    assign pr_we = w_drive && w_last && r_we;

    assign m0_done  = w_resp && (r_owner == MST_CPU);
    assign m1_done  = w_resp && (r_owner == MST_DMA);
    assign m0_err   = m0_done && r_err;
    assign m1_err   = m1_done && r_err;
    assign m0_rdata = r_rdata;
    assign m1_rdata = r_rdata;

    assign busy  = (r_state != ST_IDLE);
    assign owner = r_owner;

endmodule

// File: tb/tb_pbus_arbiter.sv
// Directed scoreboard bench for pbus_arbiter: one instance with WAIT_CYCLES=0, one with 3,
// sharing master inputs; the instance not under test is held in reset.
module tb_pbus_arbiter;

    typedef struct packed {
        logic        mst;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0, rst3, use3;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

    logic [31:0] d0_m0_rdata, d0_m1_rdata, d0_pr_a, d0_pr_wd, d0_pr_rd;
    logic        d0_m0_done, d0_m0_err, d0_m1_done, d0_m1_err, d0_pr_we, d0_busy, d0_owner;
    logic [31:0] d3_m0_rdata, d3_m1_rdata, d3_pr_a, d3_pr_wd, d3_pr_rd;
    logic        d3_m0_done, d3_m0_err, d3_m1_done, d3_m1_err, d3_pr_we, d3_busy, d3_owner;

    logic [31:0] s_m0_rdata, s_m1_rdata, s_pr_a, s_pr_wd;
    logic        s_m0_done, s_m0_err, s_m1_done, s_m1_err, s_pr_we, s_busy, s_owner;

    int          n_vec = 0;
    int          n_mis = 0;
    int          we_cnt, nz_cnt;
    logic [31:0] we_a, we_d;
    logic [31:0] a_hist [16];
    logic        we_hist [16];
    exp_t        sb [$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a == 32'h0000_7F10) ? 32'h1234_5678 : {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic addr_ok(input logic [31:0] a);
        return ((a >= 32'h7F00) && (a <= 32'h7F0B)) || ((a >= 32'h7F10) && (a <= 32'h7F1B));
    endfunction

    assign d0_pr_rd = rd_model(d0_pr_a);
    assign d3_pr_rd = rd_model(d3_pr_a);

    assign s_m0_rdata = use3 ? d3_m0_rdata : d0_m0_rdata;
    assign s_m1_rdata = use3 ? d3_m1_rdata : d0_m1_rdata;
    assign s_pr_a     = use3 ? d3_pr_a     : d0_pr_a;
    assign s_pr_wd    = use3 ? d3_pr_wd    : d0_pr_wd;
    assign s_m0_done  = use3 ? d3_m0_done  : d0_m0_done;
    assign s_m0_err   = use3 ? d3_m0_err   : d0_m0_err;
    assign s_m1_done  = use3 ? d3_m1_done  : d0_m1_done;
    assign s_m1_err   = use3 ? d3_m1_err   : d0_m1_err;
    assign s_pr_we    = use3 ? d3_pr_we    : d0_pr_we;
    assign s_busy     = use3 ? d3_busy     : d0_busy;
    assign s_owner    = use3 ? d3_owner    : d0_owner;

    pbus_arbiter #(.WAIT_CYCLES(0), .CNT_W(4)) dut0 (
        .clk(clk), .reset(rst0),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(d0_m0_rdata), .m0_done(d0_m0_done), .m0_err(d0_m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(d0_m1_rdata), .m1_done(d0_m1_done), .m1_err(d0_m1_err),
        .pr_a(d0_pr_a), .pr_we(d0_pr_we), .pr_wd(d0_pr_wd), .pr_rd(d0_pr_rd),
        .busy(d0_busy), .owner(d0_owner)
    );

    pbus_arbiter #(.WAIT_CYCLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .reset(rst3),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(d3_m0_rdata), .m0_done(d3_m0_done), .m0_err(d3_m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(d3_m1_rdata), .m1_done(d3_m1_done), .m1_err(d3_m1_err),
        .pr_a(d3_pr_a), .pr_we(d3_pr_we), .pr_wd(d3_pr_wd), .pr_rd(d3_pr_rd),
        .busy(d3_busy), .owner(d3_owner)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " pr_a"},     s_pr_a,           32'h0);
        check({tag, " pr_wd"},    s_pr_wd,          32'h0);
        check({tag, " pr_we"},    32'(s_pr_we),     32'h0);
        check({tag, " busy"},     32'(s_busy),      32'h0);
        check({tag, " owner"},    32'(s_owner),     32'h0);
        check({tag, " m0_done"},  32'(s_m0_done),   32'h0);
        check({tag, " m1_done"},  32'(s_m1_done),   32'h0);
        check({tag, " m0_err"},   32'(s_m0_err),    32'h0);
        check({tag, " m1_err"},   32'(s_m1_err),    32'h0);
        check({tag, " m0_rdata"}, s_m0_rdata,       32'h0);
        check({tag, " m1_rdata"}, s_m1_rdata,       32'h0);
    endtask

    // Waits (bounded) for the next done, pops the scoreboard and compares the response.
    task automatic collect(input string tag, input int exp_lat);
        exp_t e;
        bit   seen;
        int   k;
        seen = 1'b0;
        k = 0;
        we_cnt = 0;
        nz_cnt = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            if (k < 16) begin
                a_hist[k]  = s_pr_a;
                we_hist[k] = s_pr_we;
            end
            if (s_pr_we) begin
                we_cnt++;
                we_a = s_pr_a;
                we_d = s_pr_wd;
            end
            if (s_pr_a != 32'h0) nz_cnt++;
            if (s_m0_done || s_m1_done) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    check({tag, " unexpected done"}, 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    check({tag, " owner"},   32'(s_owner),   32'(e.mst));
                    check({tag, " m0_done"}, 32'(s_m0_done), 32'(!e.mst));
                    check({tag, " m1_done"}, 32'(s_m1_done), 32'(e.mst));
                    check({tag, " rdata"},   e.mst ? s_m1_rdata : s_m0_rdata, e.rdata);
                    check({tag, " err"},     32'(e.mst ? s_m1_err : s_m0_err), 32'(e.err));
                    check({tag, " other err"}, 32'(e.mst ? s_m0_err : s_m1_err), 32'h0);
                end
            end else begin
                k++;
            end
        end
        check({tag, " done seen"}, 32'(seen), 32'h1);
        check({tag, " latency"}, k, exp_lat);
    endtask

    task automatic drive(input logic mst, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        if (mst) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
    endtask

    function automatic exp_t expect_of(input logic mst, input logic we, input logic [31:0] a);
        exp_t e;
        e.mst   = mst;
        e.err   = !addr_ok(a);
        e.rdata = (we || e.err) ? 32'h0 : rd_model({a[31:2], 2'b00});
        return e;
    endfunction

    task automatic run_txn(input string tag, input logic mst, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata, input int exp_lat);
        exp_t e;
        e = expect_of(mst, we, addr);
        @(posedge clk);
        #1;
        drive(mst, we, addr, wdata);
        sb.push_back(e);
        collect(tag, exp_lat);
        @(posedge clk);
        #1;
        m0_req = 1'b0;
        m1_req = 1'b0;
        check({tag, " strobes"}, we_cnt, (we && !e.err) ? 1 : 0);
        if (we && !e.err) begin
            check({tag, " pr_a@we"},  we_a, {addr[31:2], 2'b00});
            check({tag, " pr_wd@we"}, we_d, wdata);
        end
        if (e.err) check({tag, " pr_a nonzero cycles"}, nz_cnt, 0);
    endtask

    initial begin
        rst0 = 1'b0; rst3 = 1'b0; use3 = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(negedge clk);
        check_idle("reset0");
        rst0 = 1'b1;

        run_txn("m0_wr_7f04", 1'b0, 1'b1, 32'h7F04, 32'h0000_00AA, 2);
        run_txn("m1_rd_7f10", 1'b1, 1'b0, 32'h7F10, 32'h0, 2);
        run_txn("m0_rd_7f1a", 1'b0, 1'b0, 32'h7F1A, 32'h0, 2);
        run_txn("m1_rd_7f0c", 1'b1, 1'b0, 32'h7F0C, 32'h0, 2);

        // Continuous contention: four back-to-back grants.
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'h7F08, 32'h0);
        drive(1'b1, 1'b0, 32'h7F14, 32'h0);
`ifdef PBUS_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) sb.push_back(expect_of(1'b0, 1'b0, 32'h7F08));
`else
        for (int i = 0; i < 4; i++) sb.push_back(expect_of(i[0], 1'b0, i[0] ? 32'h7F14 : 32'h7F08));
`endif
        for (int i = 0; i < 4; i++) collect($sformatf("contend%0d", i), 2);
        @(posedge clk);
        #1;
        m0_req = 1'b0;
        m1_req = 1'b0;

        run_txn("m0_wr_7f20", 1'b0, 1'b1, 32'h7F20, 32'h0000_00BB, 2);

        // Switch to the WAIT_CYCLES=3 instance.
        @(negedge clk);
        rst0 = 1'b0;
        use3 = 1'b1;
        rst3 = 1'b1;
        check_idle("reset3");
        run_txn("w3_m0_wr_7f00", 1'b0, 1'b1, 32'h7F00, 32'hDEAD_BEEF, 5);
        check("w3 pr_a idle cycle", a_hist[0], 32'h0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("w3 pr_a cyc%0d", i), a_hist[i], 32'h7F00);
            check($sformatf("w3 pr_we cyc%0d", i), 32'(we_hist[i]), (i == 4) ? 32'h1 : 32'h0);
        end

        // Reset during ACCESS of an m1 write: response is dropped.
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 32'h7F18, 32'h0000_0055);
        @(negedge clk);
        check("rst cyc0 pr_we", 32'(s_pr_we), 32'h0);
        @(negedge clk);
        check("rst cyc1 busy", 32'(s_busy), 32'h1);
        check("rst cyc1 pr_we", 32'(s_pr_we), 32'h0);
        #1;
        rst3 = 1'b0;
        #1;
        check_idle("rst async");
        m1_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst hold%0d done", i), 32'(s_m0_done | s_m1_done), 32'h0);
            check($sformatf("rst hold%0d pr_we", i), 32'(s_pr_we), 32'h0);
        end
        rst3 = 1'b1;
        run_txn("w3_m1_wr_7f18", 1'b1, 1'b1, 32'h7F18, 32'h0000_0055, 5);
        check("scoreboard empty", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/pbus_arbiter.md
Name: pbus_arbiter

Overview:
- Two-master arbiter and sequencer for the peripheral bus that feeds the system bridge and its TC1/TC2 timers.
- Master 0 is the CPU data port; master 1 is the DMA/debug port.
- Accepts one transaction at a time, round-robin when both request.
- Address-checks each transaction, drives the bridge's pr_a/pr_we/pr_wd for a configurable access window, captures pr_rd, and returns a one-cycle done (and err) to the owner.

Parameters:
WAIT_CYCLES, 0, extra ACCESS cycles before pr_rd capture/write commit (0..15)
CNT_W, 4, width of wait counter; must hold WAIT_CYCLES

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; one clock; reset is asynchronous and active-low
m0_req  input  1  master 0 request, level; held through done cycle
m0_we  input  1  master 0 write enable
m0_addr  input  32  master 0 byte address
m0_wdata  input  32  master 0 write data
m0_rdata  output  32  read data to master 0, valid with m0_done
m0_done  output  1  one-cycle completion pulse, master 0
m0_err  output  1  address error, valid with m0_done
m1_req/m1_we/m1_addr/m1_wdata/m1_rdata/m1_done/m1_err  same as m0, for master 1
pr_a  output  32  bridge address
pr_we  output  1  bridge write enable
pr_wd  output  32  bridge write data
pr_rd  input  32  bridge read data, combinational from pr_a
busy  output  1  high in ACCESS or RESP
owner  output  1  id of current/last granted master

Behaviour:
- Reset (async, reset=0): state=IDLE, pr_a=0, pr_we=0, pr_wd=0, rdata=0, done/err=0, busy=0, owner=0, last_gnt=1 (m0 wins first tie), cnt=0. A transaction in flight is dropped; no done is issued.
- States: IDLE, ACCESS, RESP.
- IDLE: if any req, pick master: single requester wins; both -> master != last_gnt. On the clock edge, latch addr (word-aligned, [1:0] forced 0), we, wdata; set owner=last_gnt=winner; cnt=WAIT_CYCLES; go to ACCESS.
- Address check at latch: valid iff addr in 0x7F00..0x7F0B or 0x7F10..0x7F1B; latch the result as err_q.
- ACCESS, valid: pr_a=latched addr and pr_wd=latched wdata for the whole state. pr_we=latched we only in the final ACCESS cycle (cnt==0), so exactly one write strobe per transaction. When cnt==0: capture pr_rd into rdata (0 if write) and go to RESP; otherwise decrement cnt.
- ACCESS, err_q=1: pr_a=0 and pr_we=0 throughout. The state still lasts WAIT_CYCLES+1 cycles; rdata=0.
- RESP: done of owner=1 and err of owner=err_q for exactly one cycle. Next state is IDLE. The other master's done/err stay 0.
- Both mN_rdata are driven from the shared rdata register; meaningful only with that master's done.
- Latency: req first seen in IDLE at cycle 0 -> done at cycle WAIT_CYCLES+2.
- Max throughput: one transaction per WAIT_CYCLES+3 cycles.
- Req contract: a master keeps req/addr/we/wdata stable until its done cycle. The cycle after done is IDLE, where a still-high req is a new transaction.
- Round-robin under continuous contention alternates strictly: m0, m1, m0, ...
- A req arriving in ACCESS/RESP waits, with no loss, until IDLE.

Optional Feature:
- PBUS_FIXED_PRIO_EN defined: tie in IDLE always goes to m0; last_gnt still tracks owner but does not affect choice. Master 1 can starve.
- Undefined: round-robin as above.

Decomposition:
- pbus_pkg: state encoding (IDLE/ACCESS/RESP), TC1/TC2 start/end address constants, master id constants.
- Sub-module rr_arb2: combinational 2-request picker, inputs req[1:0] and last_gnt, output winner and valid. Holds the PBUS_FIXED_PRIO_EN variant.
- FSM, latches and counter stay in pbus_arbiter.

Test Plan:
- WAIT_CYCLES=0, reset released; m0 write 0x7F04 data 0x0000_00AA -> pr_we high exactly one cycle with pr_a=0x7F04, pr_wd=0xAA; m0_done at cycle 2; m0_err=0.
- m1 read 0x7F10, pr_rd model returns 0x1234_5678 -> m1_done at cycle 2, m1_rdata=0x1234_5678, m0_done stays 0.
- m0 and m1 both req continuously, 4 transactions -> owners m0, m1, m0, m1; with PBUS_FIXED_PRIO_EN -> m0 four times.
- m0 write to 0x7F20 -> pr_we never asserted, pr_a stays 0, m0_done with m0_err=1, m0_rdata=0.
- WAIT_CYCLES=3, m0 write 0x7F00 -> pr_a stable 4 cycles, pr_we only in the 4th; done at cycle 5.
- reset pulled low during ACCESS of an m1 write -> all outputs 0 immediately, no done or pr_we; after release, m1 re-request completes normally.
